mfp_ahb_lite_arbiter2: RTL

MFP_AHB_LITE_ARBITER2 -- requirements
Module: mfp_ahb_lite_arbiter2

---
 rtl/mfp_ahb_lite_arbiter2.sv | 134 +++++++++++++
 1 files changed

// File: rtl/mfp_ahb_lite_arbiter2.sv
// Two-master AHB-Lite arbiter: shares one slave matrix between M0 (CPU) and M1 (DMA/debug).
// Round-robin or M0-priority grant, with data-phase tracking so responses go to the right master.
module mfp_ahb_lite_arbiter2 #(
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,

    input  logic [31:0] M0_HADDR,
    input  logic [1:0]  M0_HTRANS,
    input  logic        M0_HWRITE,
    input  logic [2:0]  M0_HSIZE,
    input  logic [2:0]  M0_HBURST,
    input  logic [3:0]  M0_HPROT,
    input  logic        M0_HMASTLOCK,
    input  logic [31:0] M0_HWDATA,
    output logic [31:0] M0_HRDATA,
    output logic        M0_HREADY,
    output logic        M0_HRESP,

    input  logic [31:0] M1_HADDR,
    input  logic [1:0]  M1_HTRANS,
    input  logic        M1_HWRITE,
    input  logic [2:0]  M1_HSIZE,
    input  logic [2:0]  M1_HBURST,
    input  logic [3:0]  M1_HPROT,
    input  logic        M1_HMASTLOCK,
    input  logic [31:0] M1_HWDATA,
    output logic [31:0] M1_HRDATA,
    output logic        M1_HREADY,
    output logic        M1_HRESP,

    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic        HMASTLOCK,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP,

    output logic        GRANT
);

    localparam logic [1:0] TRANS_IDLE = 2'b00;
    localparam logic [1:0] TRANS_SEQ  = 2'b11;
    localparam bit         PRIO_M0    = (FIXED_PRIO != 0);

    logic grant_q,   grant_d;
    logic d_owner_q, d_owner_d;
    logic d_valid_q, d_valid_d;

    logic m0_req, m1_req;
    logic owner_hold, switch_want;
    logic m0_involved, m1_involved;

    // Address/control path follows the current grant owner.
    always_comb begin
        if (grant_q) begin
            HADDR     = M1_HADDR;
            HTRANS    = M1_HTRANS;
            HWRITE    = M1_HWRITE;
            HSIZE     = M1_HSIZE;
            HBURST    = M1_HBURST;
            HPROT     = M1_HPROT;
            HMASTLOCK = M1_HMASTLOCK;
        end else begin
            HADDR     = M0_HADDR;
            HTRANS    = M0_HTRANS;
            HWRITE    = M0_HWRITE;
            HSIZE     = M0_HSIZE;
            HBURST    = M0_HBURST;
            HPROT     = M0_HPROT;
            HMASTLOCK = M0_HMASTLOCK;
        end
    end

    // Grant decision and data-phase bookkeeping at arbitration points.
    always_comb begin
        grant_d   = grant_q;
        d_owner_d = d_owner_q;
        d_valid_d = d_valid_q;

        m0_req     = M0_HTRANS[1];
        m1_req     = M1_HTRANS[1];
        owner_hold = (HTRANS == TRANS_SEQ) || HMASTLOCK;

        if (PRIO_M0) begin
            switch_want = grant_q ? m0_req : (m1_req && (M0_HTRANS == TRANS_IDLE));
        end else begin
            switch_want = grant_q ? m0_req : m1_req;
        end

        if (HREADY) begin
            d_owner_d = grant_q;
            d_valid_d = HTRANS[1];
            if (!owner_hold && switch_want) begin
                grant_d = ~grant_q;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            grant_q   <= 1'b0;
            d_owner_q <= 1'b0;
            d_valid_q <= 1'b0;
        end else begin
            grant_q   <= grant_d;
            d_owner_q <= d_owner_d;
            d_valid_q <= d_valid_d;
        end
    end

    // Response path: a master not in any phase sees a stall only while it is requesting.
    always_comb begin
        m0_involved = !grant_q || (d_valid_q && !d_owner_q);
        m1_involved =  grant_q || (d_valid_q &&  d_owner_q);

        HWDATA    = d_owner_q ? M1_HWDATA : M0_HWDATA;
        M0_HRDATA = HRDATA;
        M1_HRDATA = HRDATA;
        M0_HRESP  = d_valid_q && !d_owner_q && HRESP;
        M1_HRESP  = d_valid_q &&  d_owner_q && HRESP;
        M0_HREADY = m0_involved ? HREADY : !m0_req;
        M1_HREADY = m1_involved ? HREADY : !m1_req;
    end

    assign GRANT = grant_q;

endmodule
